gpu_raster_engine: RTL and testbench
====================================

// Module: gpu_raster_engine
// PURPOSE
//  Parametrised successor to the single-command GPU line path. APB slave queues draw commands in a FIFO.
//  A raster FSM executes them: PIXEL, all-octant Bresenham LINE, and filled RECT.
//  Streams pixels to the framebuffer writer over a valid/ready handshake, with a readable STATUS register.
// PARAMETERS
//  X_W        10  x coordinate width
//  Y_W         9  y coordinate width
//  COLOR_W     8  width of each of r/g/b
//  FIFO_DEPTH  4  command FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1        system clock
//  n_rst          in   1        async active-low reset
//  pAddr_i        in   32       APB address (bits [4:2] decoded)
//  pDataWrite_i   in   32       APB write data
//  pSel_i         in   1        APB select
//  pEnable_i      in   1        APB enable
//  pWrite_i       in   1        APB write strobe
//  pDataRead_o    out  32       APB read data
//  x_o            out  X_W      pixel x
//  y_o            out  Y_W      pixel y
//  r_o/g_o/b_o    out  COLOR_W  pixel colour
//  pixel_valid_o  out  1        pixel outputs valid
//  pixel_ready_i  in   1        downstream accepts pixel
//  busy_o         out  1        FSM != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, n_rst=0):
//   - All outputs 0; FIFO emptied; staging regs 0; overflow flag 0; FSM->IDLE.
//   - Mid-command reset abandons the command; no further pixels emitted.
//  APB:
//   - Write commits on pSel&pEnable&pWrite (access phase).
//   - 0x00 COORD1 {y1[Y_W+15:16],x1[X_W-1:0]}; 0x04 COORD2 same layout for x2/y2.
//   - 0x08 COLOR {r[23:16],g[15:8],b[7:0]} at COLOR_W=8; fields widen/narrow with COLOR_W.
//   - 0x0C CMD: op=[1:0] (0 NOP, 1 PIXEL, 2 LINE, 3 RECT).
//     Write pushes {op,x1,y1,x2,y2,rgb} snapshot; NOP is not pushed.
//   - 0x10 STATUS rd: {count[15:8], overflow[2], full[1], busy[0]}. Write 1 to bit2 clears overflow.
//   - Reads are combinational whenever pSel_i=1, else 0. Unmapped addresses read 0; writes to them are ignored.
//  FIFO:
//   - Push when full is dropped and sets overflow (sticky).
//   - Full is sampled before a same-cycle pop, so push on full is dropped even if a pop occurs that cycle.
//   - Push+pop same cycle when not full: count unchanged.
//  FSM: IDLE -> LOAD -> {PIX, LINE, RECT} -> IDLE.
//   - IDLE: if FIFO non-empty, pop, go to LOAD.
//   - LOAD: register command; compute setup; next state per op.
//   - First pixel_valid_o asserts 2 cycles after the IDLE cycle that saw non-empty.
//   - Pixel advances only on valid&ready. While valid&!ready, x/y/rgb/valid hold stable.
//   - PIX: one pixel (x1,y1).
//   - LINE: dx=|x2-x1|, dy=-|y2-y1|, sx/sy=sign, err=dx+dy. Signed err width max(X_W,Y_W)+3.
//     Per accepted pixel: e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}.
//     Ends after (x2,y2) is accepted. Endpoints included; x1==x2&&y1==y2 emits 1 pixel.
//   - RECT: corners normalised (min/max) at LOAD. Row-major from (xmin,ymin): x increments, wraps to xmin with y++.
//     Ends after (xmax,ymax) is accepted. Pixels = (xmax-xmin+1)*(ymax-ymin+1).
//   - Last pixel accepted -> IDLE next cycle. valid drops for >=1 cycle between commands.
//  Colour is constant for a command, taken from the snapshot, not live registers.
// TESTING
//  1 PIXEL (5,7) rgb=FF0000, ready=1 -> exactly one pixel (5,7) FF0000; valid high 1 cycle, 2 cycles after pop.
//  2 LINE (0,0)->(3,1) -> (0,0),(1,0),(2,1),(3,1). LINE (3,1)->(0,0) -> exact reverse-octant sequence.
//  3 RECT (4,2)->(2,3) -> 6 pixels (2,2),(3,2),(4,2),(2,3),(3,3),(4,3).
//    ready toggled 1/0 per cycle -> same sequence; outputs stable while stalled.
//  4 Push 5 CMDs with DEPTH=4 while stalled -> count=4, full=1, overflow=1, 5th never drawn.
//    Write STATUS bit2 -> overflow=0.
//  5 Reset asserted mid-LINE -> valid=0, busy=0, count=0 immediately.
//    After release, new PIXEL draws correctly.
//  6 Back-to-back LINE+RECT queued -> all pixels in order, one idle bubble, STATUS busy=1 until last accepted.

Source files
------------

// File: rtl/gpu_raster_engine.sv
// gpu_raster_engine: APB-programmed draw-command queue feeding a raster FSM
// that emits PIXEL, all-octant Bresenham LINE and filled RECT pixels over a
// valid/ready stream. STATUS exposes queue depth, sticky overflow and busy.
module gpu_raster_engine #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [31:0]        pAddr_i,
    input  logic [31:0]        pDataWrite_i,
    input  logic               pSel_i,
    input  logic               pEnable_i,
    input  logic               pWrite_i,
    output logic [31:0]        pDataRead_o,
    output logic [X_W-1:0]     x_o,
    output logic [Y_W-1:0]     y_o,
    output logic [COLOR_W-1:0] r_o,
    output logic [COLOR_W-1:0] g_o,
    output logic [COLOR_W-1:0] b_o,
    output logic               pixel_valid_o,
    input  logic               pixel_ready_i,
    output logic               busy_o
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;
    localparam int E_W   = ((X_W > Y_W) ? X_W : Y_W) + 3;

    localparam logic [2:0] REG_COORD1 = 3'd0;
    localparam logic [2:0] REG_COORD2 = 3'd1;
    localparam logic [2:0] REG_COLOR  = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam logic [1:0] OP_PIXEL = 2'd1;
    localparam logic [1:0] OP_LINE  = 2'd2;
    localparam logic [1:0] OP_RECT  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PIX, S_LINE, S_RECT} state_t;

    typedef struct packed {
        logic [1:0]         op;
        logic [X_W-1:0]     x1;
        logic [Y_W-1:0]     y1;
        logic [X_W-1:0]     x2;
        logic [Y_W-1:0]     y2;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } cmd_t;

    // APB staging registers
    logic [X_W-1:0]     st_x1_q, st_x1_d, st_x2_q, st_x2_d;
    logic [Y_W-1:0]     st_y1_q, st_y1_d, st_y2_q, st_y2_d;
    logic [COLOR_W-1:0] st_r_q, st_r_d, st_g_q, st_g_d, st_b_q, st_b_d;

    // command FIFO
    cmd_t               fifo_mem [FIFO_DEPTH];
    cmd_t               cmd_q;
    cmd_t               cmd_new;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push_req, push_ok, pop, fifo_full;

    // raster datapath
    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d, end_x_q, end_x_d, start_x_q, start_x_d;
    logic [Y_W-1:0]     y_q, y_d, end_y_q, end_y_d;
    logic [COLOR_W-1:0] col_r_q, col_r_d, col_g_q, col_g_d, col_b_q, col_b_d;
    logic signed [E_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic               sx_q, sx_d, sy_q, sy_d;

    // LOAD-time line setup and per-step terms
    logic signed [E_W-1:0] dxr, dyr, dx_set, dy_set, e2;
    logic               sx_set, sy_set, fire;

    logic               apb_wr;
    logic [2:0]         reg_idx;
    logic               unused_apb;

    assign apb_wr     = pSel_i & pEnable_i & pWrite_i;
    assign reg_idx    = pAddr_i[4:2];
    assign unused_apb = ^{pAddr_i[31:5], pAddr_i[1:0], pDataWrite_i};

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok    = push_req & ~fifo_full;

    assign pixel_valid_o = (state_q == S_PIX) || (state_q == S_LINE) || (state_q == S_RECT);
    assign fire          = pixel_valid_o & pixel_ready_i;
    assign busy_o        = (state_q != S_IDLE) || (count_q != '0);
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign r_o           = col_r_q;
    assign g_o           = col_g_q;
    assign b_o           = col_b_q;

    // APB register writes, push request and sticky overflow (set beats clear)
    always_comb begin
        st_x1_d    = st_x1_q;
        st_y1_d    = st_y1_q;
        st_x2_d    = st_x2_q;
        st_y2_d    = st_y2_q;
        st_r_d     = st_r_q;
        st_g_d     = st_g_q;
        st_b_d     = st_b_q;
        push_req   = 1'b0;
        overflow_d = overflow_q;
        if (apb_wr) begin
            case (reg_idx)
                REG_COORD1: begin
                    st_x1_d = pDataWrite_i[X_W-1:0];
                    st_y1_d = pDataWrite_i[16 +: Y_W];
                end
                REG_COORD2: begin
                    st_x2_d = pDataWrite_i[X_W-1:0];
                    st_y2_d = pDataWrite_i[16 +: Y_W];
                end
                REG_COLOR: begin
                    st_b_d = pDataWrite_i[0 +: COLOR_W];
                    st_g_d = pDataWrite_i[COLOR_W +: COLOR_W];
                    st_r_d = pDataWrite_i[2*COLOR_W +: COLOR_W];
                end
                REG_CMD:    push_req = (pDataWrite_i[1:0] != 2'd0);
                REG_STATUS: if (pDataWrite_i[2]) overflow_d = 1'b0;
                default: ;
            endcase
        end
        if (push_req && fifo_full) overflow_d = 1'b1;
    end

    // snapshot of the staging registers taken when CMD is written
    always_comb begin
        cmd_new    = '0;
        cmd_new.op = pDataWrite_i[1:0];
        cmd_new.x1 = st_x1_q;
        cmd_new.y1 = st_y1_q;
        cmd_new.x2 = st_x2_q;
        cmd_new.y2 = st_y2_q;
        cmd_new.r  = st_r_q;
        cmd_new.g  = st_g_q;
        cmd_new.b  = st_b_q;
    end

    // FIFO pointer and occupancy update; full is judged before any same-cycle pop
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // APB read mux, combinational while selected
    always_comb begin
        pDataRead_o = '0;
        if (pSel_i) begin
            case (reg_idx)
                REG_COORD1: begin
                    pDataRead_o[X_W-1:0]    = st_x1_q;
                    pDataRead_o[16 +: Y_W]  = st_y1_q;
                end
                REG_COORD2: begin
                    pDataRead_o[X_W-1:0]    = st_x2_q;
                    pDataRead_o[16 +: Y_W]  = st_y2_q;
                end
                REG_COLOR: begin
                    pDataRead_o[0 +: COLOR_W]         = st_b_q;
                    pDataRead_o[COLOR_W +: COLOR_W]   = st_g_q;
                    pDataRead_o[2*COLOR_W +: COLOR_W] = st_r_q;
                end
                REG_STATUS: begin
                    pDataRead_o[8 +: CNT_W] = count_q;
                    pDataRead_o[2]          = overflow_q;
                    pDataRead_o[1]          = fifo_full;
                    pDataRead_o[0]          = busy_o;
                end
                default: pDataRead_o = '0;
            endcase
        end
    end

    // staging registers, FIFO pointers and flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st_x1_q    <= '0;
            st_y1_q    <= '0;
            st_x2_q    <= '0;
            st_y2_q    <= '0;
            st_r_q     <= '0;
            st_g_q     <= '0;
            st_b_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            st_x1_q    <= st_x1_d;
            st_y1_q    <= st_y1_d;
            st_x2_q    <= st_x2_d;
            st_y2_q    <= st_y2_d;
            st_r_q     <= st_r_d;
            st_g_q     <= st_g_d;
            st_b_q     <= st_b_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage with registered read; popped entry lands in cmd_q for LOAD
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= cmd_new;
        if (pop)     cmd_q <= fifo_mem[rd_ptr_q];
    end

    // Bresenham setup from the popped command
    always_comb begin
        dxr    = signed'(E_W'(cmd_q.x2)) - signed'(E_W'(cmd_q.x1));
        dyr    = signed'(E_W'(cmd_q.y2)) - signed'(E_W'(cmd_q.y1));
        sx_set = dxr[E_W-1];
        sy_set = dyr[E_W-1];
        dx_set = sx_set ? -dxr : dxr;
        dy_set = sy_set ? dyr : -dyr;
        e2     = err_q <<< 1;
    end

    // raster FSM next state and pixel datapath
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        end_x_d   = end_x_q;
        end_y_d   = end_y_q;
        start_x_d = start_x_q;
        col_r_d   = col_r_q;
        col_g_d   = col_g_q;
        col_b_d   = col_b_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                col_r_d = cmd_q.r;
                col_g_d = cmd_q.g;
                col_b_d = cmd_q.b;
                x_d     = cmd_q.x1;
                y_d     = cmd_q.y1;
                end_x_d = cmd_q.x2;
                end_y_d = cmd_q.y2;
                case (cmd_q.op)
                    OP_PIXEL: state_d = S_PIX;
                    OP_LINE: begin
                        dx_d    = dx_set;
                        dy_d    = dy_set;
                        sx_d    = sx_set;
                        sy_d    = sy_set;
                        err_d   = dx_set + dy_set;
                        state_d = S_LINE;
                    end
                    OP_RECT: begin
                        x_d       = (cmd_q.x1 < cmd_q.x2) ? cmd_q.x1 : cmd_q.x2;
                        start_x_d = (cmd_q.x1 < cmd_q.x2) ? cmd_q.x1 : cmd_q.x2;
                        end_x_d   = (cmd_q.x1 < cmd_q.x2) ? cmd_q.x2 : cmd_q.x1;
                        y_d       = (cmd_q.y1 < cmd_q.y2) ? cmd_q.y1 : cmd_q.y2;
                        end_y_d   = (cmd_q.y1 < cmd_q.y2) ? cmd_q.y2 : cmd_q.y1;
                        state_d   = S_RECT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_PIX: begin
                if (fire) state_d = S_IDLE;
            end
            S_LINE: begin
                if (fire) begin
                    if ((x_q == end_x_q) && (y_q == end_y_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        if (e2 >= dy_q) begin
                            err_d = err_d + dy_q;
                            x_d   = sx_q ? x_q - X_W'(1) : x_q + X_W'(1);
                        end
                        if (e2 <= dx_q) begin
                            err_d = err_d + dx_q;
                            y_d   = sy_q ? y_q - Y_W'(1) : y_q + Y_W'(1);
                        end
                    end
                end
            end
            S_RECT: begin
                if (fire) begin
                    if (x_q == end_x_q) begin
                        if (y_q == end_y_q) begin
                            state_d = S_IDLE;
                        end else begin
                            x_d = start_x_q;
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // raster FSM state and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            end_x_q   <= '0;
            end_y_q   <= '0;
            start_x_q <= '0;
            col_r_q   <= '0;
            col_g_q   <= '0;
            col_b_q   <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            end_x_q   <= end_x_d;
            end_y_q   <= end_y_d;
            start_x_q <= start_x_d;
            col_r_q   <= col_r_d;
            col_g_q   <= col_g_d;
            col_b_q   <= col_b_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
        end
    end

endmodule

// File: tb/tb_gpu_raster_engine.sv
// Bench for gpu_raster_engine: table of draw commands with their exact pixel
// sequences, a scoreboard queue checked on every accepted pixel, and hand
// sequences for latency, stalls, FIFO overflow, reset and back-to-back work.
module tb_gpu_raster_engine;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  r, g, b;
    logic        valid, ready, busy;

    always #5 clk = ~clk;

    gpu_raster_engine dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pAddr_i      (paddr),
        .pDataWrite_i (pwdata),
        .pSel_i       (psel),
        .pEnable_i    (penable),
        .pWrite_i     (pwrite),
        .pDataRead_o  (prdata),
        .x_o          (x),
        .y_o          (y),
        .r_o          (r),
        .g_o          (g),
        .b_o          (b),
        .pixel_valid_o(valid),
        .pixel_ready_i(ready),
        .busy_o       (busy)
    );

    typedef struct {
        int          px;
        int          py;
        logic [23:0] rgb;
        int          tag;
    } pix_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [9:0]       x1;
        logic [8:0]       y1;
        logic [9:0]       x2;
        logic [8:0]       y2;
        logic [23:0]      rgb;
        logic [3:0]       n;
        logic [5:0][9:0]  px;
        logic [5:0][8:0]  py;
    } vec_t;

    vec_t        vt [8];
    int          nv = 0;
    pix_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;   // 0 always ready, 1 toggle, 2 stalled
    int          last_tag = -1;
    int          next_tag = 0;
    bit          saw_gap = 1'b1;
    bit          stall_prev = 1'b0;
    logic [42:0] stall_snap;
    logic [31:0] rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // one clock: drive ready for this cycle, then check the pixel stream
    task automatic cycle();
        pix_t e;
        @(negedge clk);
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'b0;
        endcase
        if (!valid) saw_gap = 1'b1;
        if (stall_prev) chk("stall_hold", {valid, x, y, r, g, b}, {1'b1, stall_snap});
        stall_prev = valid & ~ready;
        stall_snap = {x, y, r, g, b};
        if (valid && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pixel", {x, y, r, g, b}, 64'h0);
                if ({x, y, r, g, b} == 43'h0) chk("unexpected_pixel_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("PIX  tag=%0d x=%0d y=%0d rgb=%02h%02h%02h", e.tag, x, y, r, g, b);
                chk("pixel", {x, y, r, g, b}, {10'(e.px), 9'(e.py), e.rgb});
                if (e.tag != last_tag) chk("gap_between_cmds", saw_gap, 1);
                last_tag = e.tag;
                saw_gap  = 1'b0;
            end
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        cycle();
        penable = 1'b1;
        cycle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        #1;
        d = prdata;
        psel = 1'b0;
    endtask

    task automatic issue(input int op, input int x1, input int y1, input int x2,
                         input int y2, input logic [23:0] rgb);
        apb_write(32'h00, (32'(y1) << 16) | 32'(x1));
        apb_write(32'h04, (32'(y2) << 16) | 32'(x2));
        apb_write(32'h08, {8'h00, rgb});
        apb_write(32'h0C, 32'(op));
    endtask

    task automatic expect_pix(input int px, input int py, input logic [23:0] rgb, input int tag);
        pix_t p;
        p.px = px; p.py = py; p.rgb = rgb; p.tag = tag;
        sb.push_back(p);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        bit busy_ok = 1'b1;
        while ((sb.size() != 0 || busy) && n < bound) begin
            cycle();
            if (sb.size() != 0 && !busy) busy_ok = 1'b0;
            n++;
        end
        chk({name, "_done"}, 64'(n < bound), 1);
        chk({name, "_busy_held"}, 64'(busy_ok), 1);
        if (n >= bound) sb.delete();
    endtask

    task automatic addv(input int op, input int x1, input int y1, input int x2,
                        input int y2, input logic [23:0] rgb);
        vt[nv] = '0;
        vt[nv].op = 2'(op); vt[nv].x1 = 10'(x1); vt[nv].y1 = 9'(y1);
        vt[nv].x2 = 10'(x2); vt[nv].y2 = 9'(y2); vt[nv].rgb = rgb;
        nv++;
    endtask

    task automatic addp(input int px, input int py);
        int k = nv - 1;
        vt[k].px[vt[k].n] = 10'(px);
        vt[k].py[vt[k].n] = 9'(py);
        vt[k].n = vt[k].n + 4'd1;
    endtask

    task automatic run_vec(input int i);
        for (int j = 0; j < int'(vt[i].n); j++)
            expect_pix(int'(vt[i].px[j]), int'(vt[i].py[j]), vt[i].rgb, next_tag);
        next_tag++;
        issue(int'(vt[i].op), int'(vt[i].x1), int'(vt[i].y1), int'(vt[i].x2),
              int'(vt[i].y2), vt[i].rgb);
        wait_drain($sformatf("vec%0d", i), 200);
    endtask

    initial begin
        // command table with exact expected pixel sequences
        addv(2, 0, 0, 3, 1, 24'h112233); addp(0,0); addp(1,0); addp(2,1); addp(3,1);
        addv(2, 3, 1, 0, 0, 24'h445566); addp(3,1); addp(2,1); addp(1,0); addp(0,0);
        addv(3, 4, 2, 2, 3, 24'h778899); addp(2,2); addp(3,2); addp(4,2);
                                         addp(2,3); addp(3,3); addp(4,3);
        addv(2, 1, 1, 2, 4, 24'hA0B0C0); addp(1,1); addp(1,2); addp(2,3); addp(2,4);
        addv(2, 7, 7, 7, 7, 24'h0F0F0F); addp(7,7);
        addv(2, 2, 0, 0, 2, 24'h00CC00); addp(2,0); addp(1,1); addp(0,2);
        addv(3, 9, 9, 9, 9, 24'h0000EE); addp(9,9);
        addv(1, 1023, 511, 0, 0, 24'h123456); addp(1023,511);

        paddr = '0; pwdata = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        ready = 1'b1; n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pixel_out", {x, y, r, g, b}, 0);
        apb_read(32'h10, rd); chk("rst_status", rd, 0);
        n_rst = 1'b1;
        cycle();

        // PIXEL latency: valid high for one cycle, two cycles after the pop
        expect_pix(5, 7, 24'hFF0000, next_tag); next_tag++;
        issue(1, 5, 7, 0, 0, 24'hFF0000);
        apb_read(32'h00, rd); chk("coord1_readback", rd, 32'h0007_0005);
        apb_read(32'h08, rd); chk("color_readback", rd, 32'h00FF_0000);
        chk("t1_valid_c0", valid, 0);
        cycle(); chk("t1_valid_c1", valid, 0);
        cycle(); chk("t1_valid_c2", valid, 1);
        cycle(); chk("t1_valid_c3", valid, 0);
        wait_drain("t1", 50);

        // register map corner cases
        apb_write(32'h14, 32'hFFFF_FFFF);
        apb_read(32'h14, rd); chk("unmapped_read", rd, 0);
        apb_read(32'h00, rd); chk("coord1_after_unmapped", rd, 32'h0007_0005);
        paddr = 32'h00; psel = 1'b0; #1; chk("read_unselected", prdata, 0);
        apb_write(32'h0C, 32'h0);
        apb_read(32'h10, rd); chk("nop_not_pushed", rd, 0);

        // table-driven commands, always ready
        for (int i = 0; i < nv; i++) run_vec(i);

        // RECT with ready toggling every cycle
        ready_mode = 1;
        run_vec(2);
        ready_mode = 0;

        // overflow: one command stalled in the FSM, then five pushes
        ready_mode = 2;
        expect_pix(10, 10, 24'h0000AA, next_tag); next_tag++;
        issue(1, 10, 10, 0, 0, 24'h0000AA);
        for (int k = 0; k < 4; k++) begin
            expect_pix(11 + k, 10, 24'h0000AA + 24'(k + 1), next_tag); next_tag++;
            issue(1, 11 + k, 10, 0, 0, 24'h0000AA + 24'(k + 1));
        end
        issue(1, 99, 99, 0, 0, 24'hDEAD00);
        apb_read(32'h10, rd); chk("ovf_status", rd, 32'h0000_0407);
        apb_write(32'h10, 32'h4);
        apb_read(32'h10, rd); chk("ovf_cleared", rd, 32'h0000_0403);
        ready_mode = 0;
        wait_drain("ovf_drain", 200);
        apb_read(32'h10, rd); chk("ovf_final_status", rd, 0);

        // reset in the middle of a long LINE with another command queued
        for (int k = 0; k <= 20; k++) expect_pix(k, 0, 24'h808080, next_tag);
        next_tag++;
        issue(2, 0, 0, 20, 0, 24'h808080);
        issue(1, 3, 3, 0, 0, 24'h010101);
        chk("mid_line_valid", valid, 1);
        apb_read(32'h10, rd); chk("mid_line_status", rd, 32'h0000_0101);
        n_rst = 1'b0;
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        apb_read(32'h10, rd); chk("reset_status", rd, 0);
        apb_read(32'h00, rd); chk("reset_coord1", rd, 0);
        sb.delete();
        stall_prev = 1'b0;
        cycle(); cycle();
        chk("reset_held_valid", valid, 0);
        n_rst = 1'b1;
        cycle();
        expect_pix(8, 9, 24'h00FF00, next_tag); next_tag++;
        issue(1, 8, 9, 0, 0, 24'h00FF00);
        wait_drain("post_reset", 50);

        // back-to-back LINE then RECT, queued while stalled
        ready_mode = 2;
        for (int j = 0; j < int'(vt[0].n); j++)
            expect_pix(int'(vt[0].px[j]), int'(vt[0].py[j]), 24'hCAFE01, next_tag);
        next_tag++;
        issue(2, 0, 0, 3, 1, 24'hCAFE01);
        for (int j = 0; j < int'(vt[2].n); j++)
            expect_pix(int'(vt[2].px[j]), int'(vt[2].py[j]), 24'hCAFE02, next_tag);
        next_tag++;
        issue(3, 4, 2, 2, 3, 24'hCAFE02);
        apb_read(32'h10, rd); chk("b2b_status", rd, 32'h0000_0101);
        ready_mode = 0;
        wait_drain("b2b", 200);
        chk("b2b_busy_after", busy, 0);
        apb_read(32'h10, rd); chk("final_status", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
